// File: rtl/io_key_ctrl.sv
// Push-button input controller: per-key 2-flop synchroniser, debounce FSM and accept pulse,
// LED toggle/press-count state, and CPU-visible event flags cleared by port reads.
module io_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  key,
  input  logic        clr,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [9:0]  led,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [1:0]  evt_pending,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT} key_state_e;

  key_state_e       state_q [4];
  key_state_e       state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       accept;
  logic [9:0]       led_q, led_d;
  logic [1:0]       evt_q, evt_d;
  logic [1:0]       evt_set, evt_clr;
  logic [2:0]       cnt_lo, cnt_hi;

  // Synchronisers idle at 1 so a reset never looks like a press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    accept = '0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        IDLE: begin
          if (!sync2_q[k]) begin
            state_d[k] = PRESS_WAIT;
            cnt_d[k]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync2_q[k]) begin
            state_d[k] = IDLE;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = PRESSED;
            accept[k]  = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (sync2_q[k]) begin
            state_d[k] = REL_WAIT;
            cnt_d[k]   = '0;
          end
        end
        REL_WAIT: begin
          if (!sync2_q[k]) begin
            state_d[k] = PRESSED;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Simultaneous accepts on a key pair add 2 to the pair's 3-bit wrapping count.
  always_comb begin
    cnt_lo = led_q[4:2] + {2'b00, accept[0]} + {2'b00, accept[1]};
    cnt_hi = led_q[9:7] + {2'b00, accept[2]} + {2'b00, accept[3]};
    led_d  = led_q;
    if (clr) begin
      led_d = '0;
    end else begin
      led_d[0]   = led_q[0] ^ accept[0];
      led_d[1]   = led_q[1] ^ accept[1];
      led_d[4:2] = cnt_lo;
      led_d[5]   = led_q[5] ^ accept[2];
      led_d[6]   = led_q[6] ^ accept[3];
      led_d[9:7] = cnt_hi;
    end
    evt_set = {|accept[3:2], |accept[1:0]};
    evt_clr = rd_en ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    // Set beats a same-cycle read clear so no event is lost.
    evt_d   = evt_set | (evt_q & ~evt_clr);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      led_q <= '0;
      evt_q <= '0;
    end else begin
      led_q <= led_d;
      evt_q <= evt_d;
    end
  end

  assign led         = led_q;
  assign in_port0    = {27'b0, led_q[4:0]};
  assign in_port1    = {27'b0, led_q[9:5]};
  assign evt_pending = evt_q;
  assign irq         = |evt_q;

endmodule
